// File: rtl/pseudo_spi_xfer_pkg.sv
// rtl/pseudo_spi_xfer_pkg.sv - shared state, phase and mode encodings for the transfer engine
// Contents: spi_state_t (word-level FSM), spi_phase_t (four phases of one serial bit),
//           MODE_READ / MODE_WRITE transfer direction constants.
package pseudo_spi_xfer_pkg;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_ADDR,
    SPI_READ,
    SPI_SHIFT,
    SPI_LATCH,
    SPI_WRITE,
    SPI_DONE
  } spi_state_t;

  // P0 setup, P1 SCLK1 high, P2 both low, P3 SCLK2 high
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_SCLK1,
    PH_GAP,
    PH_SCLK2
  } spi_phase_t;

  localparam logic MODE_READ  = 1'b0;  // SRAM -> spi_so
  localparam logic MODE_WRITE = 1'b1;  // spi_si -> SRAM

endpackage

// File: rtl/pseudo_spi_xfer_if.sv
// rtl/pseudo_spi_xfer_if.sv - control, SRAM and serial-chain signals of the transfer engine
// Signals: bgn/mode/msb_first/addr_bgn/data_len/freq_div (request), pi/cen/d_we/a/po (SRAM),
//          spi_si/spi_so/sclk1/sclk2/lat (shift chain), busy/spi_is_done (status).
// master: engine side; slave: host, SRAM and chain side.
interface pseudo_spi_xfer_if #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int DATA_LEN_WIDTH    = 8,
  parameter int DIV_WIDTH         = 8
);

  logic                         bgn;
  logic                         mode;
  logic                         msb_first;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_bgn;
  logic [DATA_LEN_WIDTH-1:0]    data_len;
  logic [DIV_WIDTH-1:0]         freq_div;
  logic [MEMORY_DATA_WIDTH-1:0] pi;
  logic                         spi_si;
  logic                         sclk1;
  logic                         sclk2;
  logic                         lat;
  logic                         spi_so;
  logic                         cen;
  logic                         d_we;
  logic [MEMORY_ADDR_WIDTH-1:0] a;
  logic [MEMORY_DATA_WIDTH-1:0] po;
  logic                         busy;
  logic                         spi_is_done;

  modport master (
    input  bgn, mode, msb_first, addr_bgn, data_len, freq_div, pi, spi_si,
    output sclk1, sclk2, lat, spi_so, cen, d_we, a, po, busy, spi_is_done
  );

  modport slave (
    output bgn, mode, msb_first, addr_bgn, data_len, freq_div, pi, spi_si,
    input  sclk1, sclk2, lat, spi_so, cen, d_we, a, po, busy, spi_is_done
  );

endinterface

// File: rtl/pseudo_spi_xfer_phase_gen.sv
// rtl/pseudo_spi_xfer_phase_gen.sv - bit-rate divider and four-phase sequencer (spi_phase_gen)
// Ports: clk, rst (sync, active high); run (count while high), clr (restart at P0),
//        div (phase length minus one); phase_nxt (phase in effect next cycle),
//        phase_end (last cycle of a phase), bit_end (last cycle of P3).
module spi_phase_gen
  import pseudo_spi_xfer_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output spi_phase_t           phase_nxt,
  output logic                 phase_end,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt;
  spi_phase_t           phase;

  assign phase_end = run && (cnt == div);
  assign bit_end   = phase_end && (phase == PH_SCLK2);

  // Exposed so the top can register its clock outputs one cycle ahead.
  always_comb begin
    phase_nxt = phase;
    if (clr || !run)
      phase_nxt = PH_SETUP;
    else if (phase_end)
      phase_nxt = spi_phase_t'(phase + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr || !run) begin
      cnt   <= '0;
      phase <= PH_SETUP;
    end else if (phase_end) begin
      cnt   <= '0;
      phase <= phase_nxt;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pseudo_spi_xfer.sv
// rtl/pseudo_spi_xfer.sv - SRAM <-> two-phase shift chain word transfer engine
// Ports: clk, rst (sync, active high); bus (pseudo_spi_xfer_if.master): request inputs,
//        SRAM port (cen/d_we/a/po/pi), chain (sclk1/sclk2/lat/spi_so/spi_si), busy, spi_is_done.
// All outputs are registered from next-state values so they line up with the state they describe.
module pseudo_spi_xfer
  import pseudo_spi_xfer_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int DATA_LEN_WIDTH    = 8,
  parameter int DIV_WIDTH         = 8
) (
  input  logic               clk,
  input  logic               rst,
  pseudo_spi_xfer_if.master  bus
);

  localparam int W  = MEMORY_DATA_WIDTH;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  spi_state_t                   state, state_nxt;
  spi_phase_t                   phase_nxt;
  logic                         phase_end, bit_end, accept, run;
  logic                         mode_r, msb_r, in_bit;
  logic [DIV_WIDTH-1:0]         div_r;
  logic [MEMORY_ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [DATA_LEN_WIDTH-1:0]    words_left, words_nxt;
  logic [BW-1:0]                bit_cnt, bit_nxt;
  logic [W-1:0]                 shreg, shreg_nxt;

  // Counters restart on every state change so each SHIFT/LATCH begins at P0.
  assign run = (state == SPI_SHIFT) || (state == SPI_LATCH);

  spi_phase_gen #(.DIV_WIDTH(DIV_WIDTH)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .clr       (state_nxt != state),
    .div       (div_r),
    .phase_nxt (phase_nxt),
    .phase_end (phase_end),
    .bit_end   (bit_end)
  );

  // Read mode shifts zeros in behind the outgoing data; write mode shifts spi_si in.
  assign in_bit = (mode_r == MODE_WRITE) ? bus.spi_si : 1'b0;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    words_nxt = words_left;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    accept    = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (bus.bgn) begin
          accept    = 1'b1;
          addr_nxt  = bus.addr_bgn;
          words_nxt = bus.data_len;
          bit_nxt   = '0;
          if (bus.data_len == '0)
            state_nxt = SPI_DONE;
          else if (bus.mode == MODE_WRITE)
            state_nxt = SPI_SHIFT;
          else
            state_nxt = SPI_ADDR;
        end
      end
      SPI_ADDR: state_nxt = SPI_READ;
      SPI_READ: begin
        shreg_nxt = bus.pi;
        state_nxt = SPI_SHIFT;
      end
      SPI_SHIFT: begin
        if (bit_end) begin
          shreg_nxt = msb_r ? {shreg[W-2:0], in_bit} : {in_bit, shreg[W-1:1]};
          if (bit_cnt == BW'(W - 1)) begin
            bit_nxt   = '0;
            state_nxt = SPI_LATCH;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      SPI_LATCH: begin
        if (phase_end) begin
          if (mode_r == MODE_WRITE) begin
            state_nxt = SPI_WRITE;
          end else begin
            words_nxt = words_left - 1'b1;
            addr_nxt  = addr + 1'b1;
            state_nxt = (words_left == DATA_LEN_WIDTH'(1)) ? SPI_DONE : SPI_ADDR;
          end
        end
      end
      SPI_WRITE: begin
        words_nxt = words_left - 1'b1;
        addr_nxt  = addr + 1'b1;
        state_nxt = (words_left == DATA_LEN_WIDTH'(1)) ? SPI_DONE : SPI_SHIFT;
      end
      SPI_DONE: state_nxt = SPI_IDLE;
      default:  state_nxt = SPI_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= SPI_IDLE;
      addr            <= '0;
      words_left      <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      mode_r          <= MODE_READ;
      msb_r           <= 1'b0;
      div_r           <= '0;
      bus.sclk1       <= 1'b0;
      bus.sclk2       <= 1'b0;
      bus.lat         <= 1'b0;
      bus.spi_so      <= 1'b0;
      bus.cen         <= 1'b1;
      bus.d_we        <= 1'b0;
      bus.a           <= '0;
      bus.po          <= '0;
      bus.busy        <= 1'b0;
      bus.spi_is_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      words_left <= words_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      if (accept) begin
        mode_r <= bus.mode;
        msb_r  <= bus.msb_first;
        div_r  <= bus.freq_div;
      end
      bus.sclk1 <= (state_nxt == SPI_SHIFT) && (phase_nxt == PH_SCLK1);
      bus.sclk2 <= (state_nxt == SPI_SHIFT) && (phase_nxt == PH_SCLK2);
      bus.lat   <= (state_nxt == SPI_LATCH);
      // mode_r is stale on the accept cycle, but read mode never goes IDLE -> SHIFT.
      if ((state_nxt == SPI_SHIFT) && (state != SPI_IDLE) && (mode_r == MODE_READ))
        bus.spi_so <= msb_r ? shreg_nxt[W-1] : shreg_nxt[0];
      else
        bus.spi_so <= 1'b0;
      bus.cen  <= !((state_nxt == SPI_ADDR) || (state_nxt == SPI_WRITE));
      bus.d_we <= (state_nxt == SPI_WRITE);
      if ((state_nxt == SPI_ADDR) || (state_nxt == SPI_WRITE))
        bus.a <= addr_nxt;
      if (state_nxt == SPI_WRITE)
        bus.po <= shreg_nxt;
      bus.busy <= !((state_nxt == SPI_IDLE) || (state_nxt == SPI_DONE));
      if (state_nxt == SPI_DONE)
        bus.spi_is_done <= 1'b1;
      else if (accept)
        bus.spi_is_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pseudo_spi_xfer.sv
// tb/tb_pseudo_spi_xfer.sv - scoreboard bench for pseudo_spi_xfer with SRAM and shift-chain models
module tb_pseudo_spi_xfer;
  import pseudo_spi_xfer_pkg::*;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int LW = 8;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pseudo_spi_xfer_if #(
    .MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .DATA_LEN_WIDTH(LW), .DIV_WIDTH(VW)
  ) bus ();

  pseudo_spi_xfer #(
    .MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .DATA_LEN_WIDTH(LW), .DIV_WIDTH(VW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          vec_cnt = 0;
  int          miscmp_cnt = 0;
  int unsigned cyc = 0;

  logic [DW-1:0] mem [512];
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_word_q [$];
  logic [DW-1:0] exp_wr_q [$];
  logic [DW-1:0] si_words [$];

  logic cur_mode = 1'b0;
  logic cur_msb = 1'b0;
  int   cur_div = 0;
  int   exp_period = 0;

  int overlap_cnt = 0, bad_pulse_cnt = 0, cen_low_cnt = 0, sclk_cnt = 0, so_bad_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous SRAM: read data appears one cycle after cen low.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.cen) begin
      if (bus.d_we) mem[bus.a] <= bus.po;
      else          bus.pi <= mem[bus.a];
    end
  end

  // Shift-chain receiver and bus monitor, sampled mid-cycle.
  logic          p_sclk1 = 0, p_sclk2 = 0, p_lat = 0, p_we = 0, lat_seen = 0;
  int            run1 = 0, run2 = 0, runl = 0, runwe = 0, rxn = 0;
  int unsigned   lat_cyc = 0;
  logic [DW-1:0] rx = '0;

  always @(negedge clk) begin
    if (bus.sclk1 && bus.sclk2) overlap_cnt++;
    if (!bus.cen) cen_low_cnt++;
    if (bus.sclk1 || bus.sclk2) sclk_cnt++;
    if (cur_mode == MODE_WRITE && bus.spi_so) so_bad_cnt++;

    if (bus.sclk1) run1++;
    else begin
      if (p_sclk1 && run1 != cur_div + 1) bad_pulse_cnt++;
      run1 = 0;
    end
    if (bus.sclk2) run2++;
    else begin
      if (p_sclk2 && run2 != cur_div + 1) bad_pulse_cnt++;
      run2 = 0;
    end
    if (bus.lat) runl++;
    else begin
      if (p_lat && runl != cur_div + 1) bad_pulse_cnt++;
      runl = 0;
    end

    if (bus.sclk1 && !p_sclk1) begin
      rx = cur_msb ? {rx[DW-2:0], bus.spi_so} : {bus.spi_so, rx[DW-1:1]};
      rxn++;
    end

    if (bus.lat && !p_lat) begin
      if (lat_seen) check("word_period", cyc - lat_cyc, 32'(exp_period));
      lat_seen = 1'b1;
      lat_cyc  = cyc;
      if (cur_mode == MODE_READ) begin
        check("bits_per_word", 32'(rxn), 32'(DW));
        if (exp_word_q.size() == 0) check("word_extra", 32'd1, 32'd0);
        else check("so_word", 32'(rx), 32'(exp_word_q.pop_front()));
      end
      rxn = 0;
    end

    if (!bus.cen) begin
      if (exp_addr_q.size() == 0) check("addr_extra", 32'd1, 32'd0);
      else check("sram_addr", 32'(bus.a), 32'(exp_addr_q.pop_front()));
    end
    if (bus.d_we) begin
      runwe++;
      if (exp_wr_q.size() == 0) check("write_extra", 32'd1, 32'd0);
      else check("sram_wdata", 32'(bus.po), 32'(exp_wr_q.pop_front()));
    end else begin
      if (p_we) check("d_we_width", 32'(runwe), 32'd1);
      runwe = 0;
    end

    if (!bus.busy) begin
      lat_seen = 1'b0;
      rxn      = 0;
    end
    p_sclk1 = bus.sclk1;
    p_sclk2 = bus.sclk2;
    p_lat   = bus.lat;
    p_we    = bus.d_we;
  end

  task automatic run_xfer(input logic mode, input logic msb, input logic [AW-1:0] addr,
                          input int len, input int div);
    int unsigned start;
    int per, lim, bp0, cl0, sc0, sb0;
    logic [DW-1:0] wr_exp [$];
    per = (mode == MODE_READ) ? 2 + 4*DW*(div+1) + (div+1) : 4*DW*(div+1) + (div+1) + 1;
    lim = len * per + 50;
    cur_mode = mode; cur_msb = msb; cur_div = div; exp_period = per;
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] ai;
      ai = addr + AW'(i);
      exp_addr_q.push_back(ai);
      if (mode == MODE_READ) exp_word_q.push_back(mem[ai]);
      else begin
        exp_wr_q.push_back(si_words[i]);
        wr_exp.push_back(si_words[i]);
      end
    end
    bp0 = bad_pulse_cnt; cl0 = cen_low_cnt; sc0 = sclk_cnt; sb0 = so_bad_cnt;
    @(negedge clk);
    bus.mode = mode; bus.msb_first = msb; bus.addr_bgn = addr;
    bus.data_len = LW'(len); bus.freq_div = VW'(div); bus.bgn = 1'b1;
    @(negedge clk);
    bus.bgn = 1'b0;
    start = cyc;
    check("busy_after_bgn", 32'(bus.busy), 32'(len != 0));
    if (mode == MODE_READ && len != 0) begin
      check("cen_after_bgn", 32'(bus.cen), 32'd0);
      check("a_after_bgn", 32'(bus.a), 32'(addr));
    end
    if (mode == MODE_WRITE) begin
      for (int w = 0; w < len; w++) begin
        for (int b = 0; b < DW; b++) begin
          logic [DW-1:0] word;
          word = si_words[w];
          while (!bus.sclk1 && (cyc - start) < lim) @(negedge clk);
          bus.spi_si = msb ? word[DW-1-b] : word[b];
          while (bus.sclk1 && (cyc - start) < lim) @(negedge clk);
        end
      end
    end
    while (!bus.spi_is_done && (cyc - start) < lim) @(negedge clk);
    check("done_latency", cyc - start, 32'(len * per));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
    check("word_q_left", 32'(exp_word_q.size()), 32'd0);
    check("wr_q_left", 32'(exp_wr_q.size()), 32'd0);
    check("pulse_widths", 32'(bad_pulse_cnt - bp0), 32'd0);
    if (mode == MODE_WRITE) begin
      check("so_idle_mode1", 32'(so_bad_cnt - sb0), 32'd0);
      for (int i = 0; i < len; i++)
        check("mem_writeback", 32'(mem[addr + AW'(i)]), 32'(wr_exp[i]));
    end
    if (len == 0) begin
      check("len0_no_cen", 32'(cen_low_cnt - cl0), 32'd0);
      check("len0_no_sclk", 32'(sclk_cnt - sc0), 32'd0);
    end
    si_words.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.bgn = 1'b0; bus.mode = 1'b0; bus.msb_first = 1'b0; bus.addr_bgn = '0;
    bus.data_len = '0; bus.freq_div = '0; bus.spi_si = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hAB; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h3C; mem[9'h040] = 8'hA5;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({bus.sclk1, bus.sclk2, bus.lat, bus.spi_so, bus.cen, bus.d_we,
                             bus.busy, bus.spi_is_done}), 32'h08);
    check("reset_a", 32'(bus.a), 32'd0);
    check("reset_po", 32'(bus.po), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer(MODE_READ, 1'b0, 9'h000, 14, 0);
    run_xfer(MODE_READ, 1'b1, 9'h040, 1, 3);
    run_xfer(MODE_READ, 1'b1, 9'h1FF, 2, 0);
    si_words = '{8'h3C, 8'hC2, 8'h7A};
    run_xfer(MODE_WRITE, 1'b0, 9'h010, 3, 1);
    si_words = '{8'h5A, 8'h81};
    run_xfer(MODE_WRITE, 1'b1, 9'h1FF, 2, 0);
    run_xfer(MODE_READ, 1'b0, 9'h055, 0, 2);
    check("done_held_idle", 32'(bus.spi_is_done), 32'd1);

    // Reset mid-transfer with a competing BGN held while busy.
    cur_mode = MODE_READ; cur_msb = 1'b0; cur_div = 0; exp_period = 35;
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(9'h080 + AW'(i));
      exp_word_q.push_back(mem[9'h080 + AW'(i)]);
    end
    @(negedge clk);
    bus.mode = MODE_READ; bus.msb_first = 1'b0; bus.addr_bgn = 9'h080;
    bus.data_len = 8'd4; bus.freq_div = 8'd0; bus.bgn = 1'b1;
    @(negedge clk);
    bus.bgn = 1'b0;
    check("done_cleared_on_bgn", 32'(bus.spi_is_done), 32'd0);
    repeat (18) @(negedge clk);
    bus.bgn = 1'b1; bus.addr_bgn = 9'h100; bus.data_len = 8'd1; bus.mode = MODE_WRITE;
    repeat (30) @(negedge clk);
    check("busy_held", 32'(bus.busy), 32'd1);
    check("bgn_ignored_done", 32'(bus.spi_is_done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outs", 32'({bus.sclk1, bus.sclk2, bus.lat, bus.spi_so, bus.cen, bus.d_we,
                                bus.busy, bus.spi_is_done}), 32'h08);
    check("midreset_a", 32'(bus.a), 32'd0);
    rst = 1'b0;
    bus.bgn = 1'b0;
    exp_addr_q.delete();
    exp_word_q.delete();
    repeat (3) @(negedge clk);
    check("idle_after_reset", 32'(bus.busy), 32'd0);
    run_xfer(MODE_READ, 1'b1, 9'h020, 2, 0);

    check("sclk_overlap", 32'(overlap_cnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/pseudo_spi_xfer.md
# pseudo_spi_xfer

Parametrised successor to the pseudo-SPI interface: a memory-to-serial and serial-to-memory transfer engine between an on-chip synchronous SRAM and an off-chip shift chain clocked by two-phase non-overlapping clocks (SCLK1/SCLK2) with a word latch strobe (LAT). Adds a programmable bit-rate divider, configurable data and address widths, LSB/MSB-first selection, and a serial-in write-back mode.

## Interface
- MEMORY_DATA_WIDTH, 8: word width W; bits shifted per word.
- MEMORY_ADDR_WIDTH, 9: SRAM address width.
- DATA_LEN_WIDTH, 8: width of word-count input.
- DIV_WIDTH, 8: width of FREQ_DIV.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- BGN  in  1  start request; accepted only in IDLE.
- MODE  in  1  0: SRAM→SPI_SO (read); 1: SPI_SI→SRAM (write).
- MSB_FIRST  in  1  1: bit W-1 first; 0: bit 0 first.
- ADDR_BGN  in  MEMORY_ADDR_WIDTH  first word address.
- DATA_LEN  in  DATA_LEN_WIDTH  number of words; 0 legal.
- FREQ_DIV  in  DIV_WIDTH  phase length = FREQ_DIV+1 CLK cycles.
- PI  in  W  SRAM read data, valid one cycle after CEN=0 with D_WE=0.
- SPI_SI  in  1  serial input (mode 1).
- SCLK1, SCLK2  out  1  two-phase shift clocks.
- LAT  out  1  word latch/select strobe.
- SPI_SO  out  1  serial output.
- CEN  out  1  SRAM chip enable, active low.
- D_WE  out  1  SRAM write enable, 1 = write.
- A  out  MEMORY_ADDR_WIDTH  SRAM address.
- PO  out  W  SRAM write data.
- BUSY  out  1  transfer in progress.
- spi_is_done  out  1  level; transfer complete, held until next accepted BGN or RST.

## Operation
- BGN accepted in IDLE: MODE, MSB_FIRST, ADDR_BGN, DATA_LEN, FREQ_DIV registered; later changes ignored until DONE. BGN while BUSY ignored.
- States: IDLE, ADDR, READ, SHIFT, LATCH, WRITE, DONE.
- DATA_LEN=0: IDLE→DONE, no SRAM access, no SCLK activity.
- Mode 0 per word: ADDR (CEN=0, A=addr) → READ (PI into shift reg) → SHIFT (W bits) → LATCH → ADDR for next word, or DONE.
- Mode 1 per word: SHIFT (W bits sampled from SPI_SI) → LATCH → WRITE (CEN=0, D_WE=1, A=addr, PO=assembled word, one cycle) → SHIFT or DONE.
- Bit = 4 phases of FREQ_DIV+1 cycles: P0 setup (SPI_SO updated, clocks low), P1 SCLK1=1, P2 clocks low, P3 SCLK2=1. SCLK1 and SCLK2 never high together.
- Mode 1: SPI_SI sampled on last CLK cycle of P3; bit order per MSB_FIRST.
- LATCH: LAT=1 for FREQ_DIV+1 cycles, clocks low.
- Address increments after each word, wraps modulo 2^MEMORY_ADDR_WIDTH.
- DONE: BUSY=0, spi_is_done=1, → IDLE next cycle (spi_is_done stays high).
- Mode 1: SPI_SO held 0.

## Timing
- All outputs registered. Reset values: SCLK1=SCLK2=LAT=SPI_SO=0, CEN=1, D_WE=0, A=0, PO=0, BUSY=0, spi_is_done=0; state IDLE.
- BGN high at edge t: BUSY=1 and (mode 0) CEN=0, A=ADDR_BGN from t.
- Mode 0 word = 2 + 4·W·(FREQ_DIV+1) + (FREQ_DIV+1) cycles; mode 1 word = 4·W·(FREQ_DIV+1) + (FREQ_DIV+1) + 1.
- Outside ADDR/WRITE: CEN=1, D_WE=0.
- RST mid-transfer: reset values at next edge; in-progress SRAM write suppressed if RST coincides.

## Structure
- Shared package/define file: state encodings (SPI_IDLE..SPI_DONE), phase encodings, mode constants.
- Sub-module `spi_phase_gen`: divider counter + 2-bit phase counter producing phase-end and bit-end ticks; FSM, shift register and address counter in top.

## Test plan
- Mode 0, W=8, FREQ_DIV=0, ADDR_BGN=0, DATA_LEN=14, LSB-first, SRAM preloaded (AB,00,00,3C,…) → deserialised words match SRAM; each word 35 cycles; spi_is_done after 490+1 cycles.
- Mode 0, MSB_FIRST=1, FREQ_DIV=3, 0xA5 → SO sequence 1,0,1,0,0,1,0,1; each SCLK high 4 cycles; no clock overlap.
- Mode 1, DATA_LEN=3, SI drives 0x3C,0xC2,0x7A → SRAM holds these at ADDR_BGN..+2; D_WE pulse exactly 1 cycle per word.
- ADDR_BGN=0x1FF, DATA_LEN=2 (AW=9) → addresses 0x1FF then 0x000.
- DATA_LEN=0 → DONE within 2 cycles, CEN never low, SCLKs idle.
- RST asserted mid-word, BGN held during BUSY → outputs reset next edge; second BGN ignored while BUSY; fresh BGN after RST restarts cleanly.
